// File: rtl/vc32_pkg.sv
// Shared vc32 execute-stage types and constants.
// Holds the mul/div sequencer state encoding and its step-counter width.
package vc32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Sized for the widest legal operand width (32): $clog2(32)+1.
    localparam int MULDIV_CNT_W = 6;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// A single shared add/sub serves both operations; done pulses once per result.
module muldiv_seq
    import vc32_pkg::*;
#(
    parameter int RV = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_mul,
    input  logic          start_div,
    input  logic          kill,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] result,
    output logic [RV-1:0] rem
);

    localparam logic [MULDIV_CNT_W-1:0] CNT_LOAD = MULDIV_CNT_W'(RV - 1);
    localparam logic [MULDIV_CNT_W-1:0] CNT_ONE  = MULDIV_CNT_W'(1);

    muldiv_state_t         state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    // x:   multiplicand (MUL) or dividend/quotient shift register (DIV)
    // y:   multiplier (MUL) or divisor (DIV)
    logic [RV-1:0]         acc_q, acc_d;
    logic [RV-1:0]         x_q, x_d;
    logic [RV-1:0]         y_q, y_d;
    logic [RV-1:0]         result_q, result_d;
    logic [RV-1:0]         rem_q, rem_d;
    logic                  done_q, done_d;

    logic                  sub;
    logic [RV:0]           op_x, op_y;
    logic [RV+1:0]         addsub;
    logic                  no_borrow;

    always_comb begin
        sub    = (state_q == DIV);
        op_x   = sub ? {acc_q, x_q[RV-1]} : {1'b0, acc_q};
        op_y   = sub ? {1'b0, y_q} : {1'b0, x_q};
        addsub = {1'b0, op_x} + {1'b0, (sub ? ~op_y : op_y)} + {{(RV+1){1'b0}}, sub};
        // A successful subtract leaves a remainder below the divisor, so bit RV is clear.
        no_borrow = addsub[RV+1] & ~addsub[RV];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!kill && start_mul) begin
                    state_d = MUL;
                    cnt_d   = CNT_LOAD;
                    acc_d   = '0;
                    x_d     = a;
                    y_d     = b;
                end else if (!kill && start_div) begin
                    if (b == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = '1;
                        rem_d    = a;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CNT_LOAD;
                        acc_d   = '0;
                        x_d     = a;
                        y_d     = b;
                    end
                end
            end
            MUL: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    if (y_q[0]) acc_d = addsub[RV-1:0];
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = acc_d;
                        rem_d    = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DIV: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = no_borrow ? addsub[RV-1:0] : op_x[RV-1:0];
                    x_d   = {x_q[RV-2:0], no_borrow};
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = x_d;
                        rem_d    = acc_d;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign rem    = rem_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the vc32 execute stage. It accepts one `mult` or `div` operation from the decoded instruction stream and computes it over RV+1 cycles using a radix-2 shift-add or restoring-divide datapath. It then presents the result with a one-cycle `done` pulse. The pipeline stalls on `busy`. The block is instantiated only when `MULT` is defined.

## Interface
- `RV`, 32: operand and result width. Legal values are 16 or 32.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- `start_mul`  in  1  start an unsigned multiply. Sampled only while idle.
- `start_div`  in  1  start an unsigned divide. Sampled only while idle.
- `kill`  in  1  abort the in-flight operation (trap or pipeline flush).
- `a`  in  RV  rs1 value: multiplicand or dividend. Sampled with the start signal.
- `b`  in  RV  rs2 value: multiplier or divisor. Sampled with the start signal.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse. `result` and `rem` are valid in that cycle.
- `result`  out  RV  low RV bits of the product, or the quotient.
- `rem`  out  RV  remainder for a divide. Zero for a multiply.

## Operation
- States:
  - IDLE: accepts a start.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
  - DONE: one cycle, then returns to IDLE.
- Start handling:
  - A start is accepted only in IDLE.
  - If `start_mul` and `start_div` are both high, the multiply is taken.
  - A start while busy is ignored and is not queued.
- MUL:
  - Load acc=0, mcand=a, mplier=b.
  - Each cycle: if mplier[0], acc+=mcand. Then mcand<<=1 and mplier>>=1.
  - The sum is truncated to RV bits.
  - After RV steps, result=acc and rem=0.
- DIV:
  - Load r=0, q=a.
  - Each cycle: {r,q} shift left 1. If r≥b, then r-=b and q[0]=1.
  - The compare uses an RV+1-bit subtract.
  - After RV steps, result=q and rem=r.
- Divide by zero:
  - Detected when the start is accepted (b==0).
  - Skips DIV and goes straight to DONE.
  - result={RV{1'b1}}, rem=a.
- Step counter: $clog2(RV)+1 bits. Loaded with RV-1 on start; the last step executes when the count reaches 0.
- `kill`:
  - In MUL or DIV: go to IDLE next edge. No `done` is produced, and `result`/`rem` keep their previous values.
  - In DONE: ignored, because `done` is already asserted.
  - In IDLE: `kill` has priority over a coincident start, so no start is accepted.
- `result`/`rem` hold after DONE until the next completed operation.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, rem=0, counter=0. Reset mid-operation discards the operation with no `done`.
- Start sampled at cycle 0 (start high and in IDLE).
- Normal operation:
  - Cycles 1..RV: MUL/DIV, busy=1.
  - Cycle RV+1: DONE, done=1, busy=1.
  - Start-to-done latency is RV+1 cycles (33 for RV=32).
- Divide by zero: done=1 in cycle 1 (latency 1).
- Earliest next accepted start is the cycle after DONE (cycle RV+2), giving throughput of one operation per RV+2 cycles.
- `done` is registered and never high for two consecutive cycles.
- Operands are captured at the start edge. Changes to `a`/`b` afterwards have no effect.

## Structure
- Shared package `vc32_pkg`:
  - State enum `muldiv_state_t` (IDLE, MUL, DIV, DONE), 2-bit.
  - Constant `MULDIV_CNT_W`.
- No sub-module. The adder/subtractor is shared between MUL and DIV inside `muldiv_seq`: one RV+1-bit add/sub per cycle, with the operand selected by state.

## Test plan
- MUL a=7, b=6 → done exactly 33 cycles after start, result=42, rem=0. busy high cycles 1–33.
- MUL a=0xFFFFFFFF, b=2 → result=0xFFFFFFFE (truncation). MUL a=0x10000, b=0x10000 → result=0.
- DIV a=100, b=7 → result=14, rem=2 at cycle 33. DIV a=0xFFFFFFFF, b=1 → result=0xFFFFFFFF, rem=0.
- DIV a=5, b=0 → done at cycle 1, result=0xFFFFFFFF, rem=5. A following MUL 3×4 is accepted at cycle 2 and returns 12.
- MUL started, `kill` at cycle 10 → busy=0 at cycle 11 and no done ever. Same check with `reset` at cycle 10 → all outputs zero.
- Start pulses during busy, and start_mul+start_div together (a=9, b=3) → extra starts are ignored and exactly one done pulse is produced, with result=27 (multiply priority).
